vid_box3x3: RTL and testbench



---
 rtl/vid_box3x3_if.sv | 29 ++
 rtl/vid_box3x3.sv | 178 +++++++++++++++++
 tb/tb_vid_box3x3.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_box3x3_if.sv
// Pixel-stream bundle for vid_box3x3: count-addressed RGB plus bypass select in,
// delayed counts, data-enable and filtered RGB out.
interface vid_box3x3_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned H_FRAME    = 1650,
    parameter int unsigned V_FRAME    = 750
);
    localparam int unsigned HW = $clog2(H_FRAME);
    localparam int unsigned VW = $clog2(V_FRAME);

    logic                    en;
    logic [3*DATA_WIDTH-1:0] in_data;
    logic [VW-1:0]           in_vcnt;
    logic [HW-1:0]           in_hcnt;
    logic [3*DATA_WIDTH-1:0] out_data;
    logic [VW-1:0]           out_vcnt;
    logic [HW-1:0]           out_hcnt;
    logic                    out_vde;

    modport master (
        output en, in_data, in_vcnt, in_hcnt,
        input  out_data, out_vcnt, out_hcnt, out_vde
    );

    modport slave (
        input  en, in_data, in_vcnt, in_hcnt,
        output out_data, out_vcnt, out_hcnt, out_vde
    );
endinterface

// File: rtl/vid_box3x3.sv
// 3x3 box (mean) filter on a count-addressed RGB stream; fixed 4-clock latency,
// two read-first line buffers supply rows v-1 and v-2.
module vid_box3x3 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned H_FRAME    = 1650,
    parameter int unsigned V_FRAME    = 750,
    parameter int unsigned RAM_SIZE   = 4096
) (
    input logic         clk,
    input logic         rstn,
    vid_box3x3_if.slave vid
);
    localparam int unsigned DW3 = 3 * DATA_WIDTH;
    localparam int unsigned HW  = $clog2(H_FRAME);
    localparam int unsigned VW  = $clog2(V_FRAME);
    localparam int unsigned AW  = $clog2(RAM_SIZE);
    localparam int unsigned SW  = DATA_WIDTH + 4;
    localparam int unsigned PW  = SW + 6;

    localparam logic [HW-1:0] HAct   = HW'(H_ACTIVE);
    localparam logic [VW-1:0] VAct   = VW'(V_ACTIVE);
    localparam logic [PW-1:0] MaxVal = PW'((2 ** DATA_WIDTH) - 1);

    if (RAM_SIZE < H_ACTIVE) begin : g_ram_too_small
        $error("vid_box3x3: RAM_SIZE must be >= H_ACTIVE");
    end

    // Line buffers: not reset, written only on active input.
    logic [DW3-1:0] lb0_mem [RAM_SIZE];
    logic [DW3-1:0] lb1_mem [RAM_SIZE];

    logic [AW-1:0]  addr;
    logic           in_act;
    logic [DW3-1:0] lb0_rd_d, lb1_rd_d;

    always_comb begin
        addr     = AW'(vid.in_hcnt);
        in_act   = (vid.in_hcnt < HAct) && (vid.in_vcnt < VAct);
        lb0_rd_d = lb0_mem[addr];
        lb1_rd_d = lb1_mem[addr];
    end

    // Nonblocking update makes both the LB1 copy and the registered read see old data.
    always_ff @(posedge clk) begin
        if (in_act) begin
            lb0_mem[addr] <= vid.in_data;
            lb1_mem[addr] <= lb0_mem[addr];
        end
    end

    // Stage 1
    logic           primed_q, primed_d;
    logic [DW3-1:0] s1_data_q, s1_lb0_q, s1_lb1_q;
    logic [HW-1:0]  s1_hcnt_q;
    logic [VW-1:0]  s1_vcnt_q;
    logic           s1_en_q, s1_primed_q;
    // Stage 2: window [col][row], col 0 newest, row 0 current line
    logic [2:0][2:0][DW3-1:0] win_q, win_d;
    logic [HW-1:0]  s2_hcnt_q;
    logic [VW-1:0]  s2_vcnt_q;
    logic           s2_en_q, s2_primed_q;
    // Stage 3
    logic [2:0][SW-1:0] s3_sum_q, sum_d;
    logic [DW3-1:0] s3_data_q;
    logic [HW-1:0]  s3_hcnt_q;
    logic [VW-1:0]  s3_vcnt_q;
    logic           s3_en_q, s3_primed_q;
    // Stage 4
    logic [DW3-1:0] out_data_q, out_data_d, filt;
    logic [HW-1:0]  out_hcnt_q;
    logic [VW-1:0]  out_vcnt_q;
    logic           out_vde_q, out_vde_d, border;
    logic [PW-1:0]  prod, mean;

    always_comb begin
        primed_d = primed_q | ((vid.in_hcnt == '0) && (vid.in_vcnt == '0));

        win_d    = win_q;
        win_d[0] = {s1_lb1_q, s1_lb0_q, s1_data_q};
        win_d[1] = win_q[0];
        win_d[2] = win_q[1];

        sum_d = '0;
        for (int c = 0; c < 3; c++) begin
            for (int col = 0; col < 3; col++) begin
                for (int row = 0; row < 3; row++) begin
                    sum_d[c] = sum_d[c] + SW'(win_q[col][row][c*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end
    end

    // Divide by 9 as (sum * 57) >> 9; exact for uniform windows, capped at full scale.
    always_comb begin
        filt = '0;
        prod = '0;
        mean = '0;
        for (int c = 0; c < 3; c++) begin
            prod = PW'(s3_sum_q[c]) * PW'(57);
            mean = prod >> 9;
            if (mean > MaxVal) begin
                mean = MaxVal;
            end
            filt[c*DATA_WIDTH +: DATA_WIDTH] = mean[DATA_WIDTH-1:0];
        end

        out_vde_d  = (s3_hcnt_q < HAct) && (s3_vcnt_q < VAct);
        border     = (s3_hcnt_q < HW'(2)) || (s3_vcnt_q < VW'(2));
        out_data_d = '0;
        if (out_vde_d) begin
            if (!s3_en_q) begin
                out_data_d = s3_data_q;
            end else if (s3_primed_q && !border) begin
                out_data_d = filt;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            primed_q    <= 1'b0;
            s1_data_q   <= '0;
            s1_lb0_q    <= '0;
            s1_lb1_q    <= '0;
            s1_hcnt_q   <= '0;
            s1_vcnt_q   <= '0;
            s1_en_q     <= 1'b0;
            s1_primed_q <= 1'b0;
            win_q       <= '0;
            s2_hcnt_q   <= '0;
            s2_vcnt_q   <= '0;
            s2_en_q     <= 1'b0;
            s2_primed_q <= 1'b0;
            s3_sum_q    <= '0;
            s3_data_q   <= '0;
            s3_hcnt_q   <= '0;
            s3_vcnt_q   <= '0;
            s3_en_q     <= 1'b0;
            s3_primed_q <= 1'b0;
            out_data_q  <= '0;
            out_hcnt_q  <= '0;
            out_vcnt_q  <= '0;
            out_vde_q   <= 1'b0;
        end else begin
            primed_q    <= primed_d;
            s1_data_q   <= vid.in_data;
            s1_lb0_q    <= lb0_rd_d;
            s1_lb1_q    <= lb1_rd_d;
            s1_hcnt_q   <= vid.in_hcnt;
            s1_vcnt_q   <= vid.in_vcnt;
            s1_en_q     <= vid.en;
            s1_primed_q <= primed_d;
            win_q       <= win_d;
            s2_hcnt_q   <= s1_hcnt_q;
            s2_vcnt_q   <= s1_vcnt_q;
            s2_en_q     <= s1_en_q;
            s2_primed_q <= s1_primed_q;
            s3_sum_q    <= sum_d;
            s3_data_q   <= win_q[0][0];
            s3_hcnt_q   <= s2_hcnt_q;
            s3_vcnt_q   <= s2_vcnt_q;
            s3_en_q     <= s2_en_q;
            s3_primed_q <= s2_primed_q;
            out_data_q  <= out_data_d;
            out_hcnt_q  <= s3_hcnt_q;
            out_vcnt_q  <= s3_vcnt_q;
            out_vde_q   <= out_vde_d;
        end
    end

    assign vid.out_data = out_data_q;
    assign vid.out_hcnt = out_hcnt_q;
    assign vid.out_vcnt = out_vcnt_q;
    assign vid.out_vde  = out_vde_q;

endmodule

// File: tb/tb_vid_box3x3.sv
// Directed bench for vid_box3x3 on a 16x8 active / 20x10 total frame with free-running counts.
module tb_vid_box3x3;
    localparam int HA = 16;
    localparam int VA = 8;
    localparam int HF = 20;
    localparam int VF = 10;
    localparam int HW = 5;
    localparam int VW = 4;
    localparam int HN = 4096;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    vid_box3x3_if #(.DATA_WIDTH(8), .H_FRAME(HF), .V_FRAME(VF)) vid ();

    vid_box3x3 #(
        .DATA_WIDTH(8), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_FRAME(HF), .V_FRAME(VF), .RAM_SIZE(32)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .vid  (vid)
    );

    int tests_run, tests_failed;
    int h_cur, v_cur, npix;
    logic [23:0] hd [HN];
    int          hh [HN];
    int          hv [HN];

    // Drive one pixel at the current counts, record it, advance counts, wait one clock.
    task automatic step(input logic e, input logic [23:0] d);
        vid.en      = e;
        vid.in_data = d;
        vid.in_hcnt = HW'(h_cur);
        vid.in_vcnt = VW'(v_cur);
        hd[npix % HN] = d;
        hh[npix % HN] = h_cur;
        hv[npix % HN] = v_cur;
        npix++;
        h_cur++;
        if (h_cur == HF) begin
            h_cur = 0;
            v_cur = (v_cur + 1) % VF;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_origin(input logic e, input logic [23:0] d);
        while (!(h_cur == 0 && v_cur == 0)) step(e, d);
    endtask

    task automatic test_reset();
        int j, rel;
        logic act;
        logic [23:0] exp;
        #1 rstn = 1'b0;
        #1;
        tests_run++;
        if (vid.out_data !== 24'h0 || vid.out_vde !== 1'b0 || vid.out_hcnt !== 0 ||
            vid.out_vcnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_async: data=%h vde=%b h=%0d v=%0d, expected all zero",
                     vid.out_data, vid.out_vde, vid.out_hcnt, vid.out_vcnt);
        end
        for (int k = 0; k < 6; k++) begin
            h_cur = int'($urandom_range(0, HF - 1));
            v_cur = int'($urandom_range(0, VF - 1));
            step($urandom_range(0, 1) == 1, 24'($urandom));
            tests_run++;
            if (vid.out_data !== 24'h0 || vid.out_vde !== 1'b0 || vid.out_hcnt !== 0 ||
                vid.out_vcnt !== 0) begin
                tests_failed++;
                $display("FAIL reset_hold: data=%h vde=%b h=%0d v=%0d, expected all zero",
                         vid.out_data, vid.out_vde, vid.out_hcnt, vid.out_vcnt);
            end
        end
        rstn = 1'b1;
        rel  = npix;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 24'($urandom));
            j = (npix - 4) % HN;
            tests_run++;
            if (npix - 4 < rel) begin
                if (vid.out_data !== 24'h0) begin
                    tests_failed++;
                    $display("FAIL reset_flush: data=%h, expected 0", vid.out_data);
                end
            end else begin
                act = (hh[j] < HA) && (hv[j] < VA);
                exp = act ? hd[j] : 24'h0;
                if (vid.out_data !== exp || vid.out_vde !== act ||
                    int'(vid.out_hcnt) != hh[j] || int'(vid.out_vcnt) != hv[j]) begin
                    tests_failed++;
                    $display("FAIL reset_release: data=%h vde=%b h=%0d v=%0d, expected %h %b %0d %0d",
                             vid.out_data, vid.out_vde, vid.out_hcnt, vid.out_vcnt,
                             exp, act, hh[j], hv[j]);
                end
            end
        end
    endtask

    task automatic test_uniform();
        int j;
        logic act;
        logic [23:0] exp;
        run_to_origin(1'b1, 24'h404040);
        for (int k = 0; k < VF * HF; k++) step(1'b1, 24'h404040);
        for (int k = 0; k < VF * HF; k++) begin
            step(1'b1, 24'h404040);
            j   = (npix - 4) % HN;
            act = (hh[j] < HA) && (hv[j] < VA);
            exp = (act && hh[j] >= 2 && hv[j] >= 2) ? 24'h404040 : 24'h0;
            tests_run++;
            if (vid.out_data !== exp || vid.out_vde !== act ||
                int'(vid.out_hcnt) != hh[j] || int'(vid.out_vcnt) != hv[j]) begin
                tests_failed++;
                $display("FAIL uniform: data=%h vde=%b h=%0d v=%0d, expected %h %b %0d %0d",
                         vid.out_data, vid.out_vde, vid.out_hcnt, vid.out_vcnt,
                         exp, act, hh[j], hv[j]);
            end
        end
    endtask

    task automatic test_impulse();
        int j;
        logic act;
        logic [23:0] exp;
        run_to_origin(1'b1, 24'h0);
        for (int k = 0; k < VF * HF; k++) begin
            step(1'b1, (h_cur == 6 && v_cur == 4) ? 24'hFF0000 : 24'h0);
            j   = (npix - 4) % HN;
            act = (hh[j] < HA) && (hv[j] < VA);
            exp = (act && hh[j] >= 6 && hh[j] <= 8 && hv[j] >= 4 && hv[j] <= 6) ?
                  24'h1C0000 : 24'h0;
            tests_run++;
            if (vid.out_data !== exp || vid.out_vde !== act ||
                int'(vid.out_hcnt) != hh[j] || int'(vid.out_vcnt) != hv[j]) begin
                tests_failed++;
                $display("FAIL impulse: data=%h vde=%b h=%0d v=%0d, expected %h %b %0d %0d",
                         vid.out_data, vid.out_vde, vid.out_hcnt, vid.out_vcnt,
                         exp, act, hh[j], hv[j]);
            end
        end
    endtask

    task automatic test_saturation();
        int j;
        logic act;
        logic [23:0] exp;
        run_to_origin(1'b1, 24'hFFFFFF);
        for (int k = 0; k < VF * HF; k++) begin
            step(1'b1, 24'hFFFFFF);
            j   = (npix - 4) % HN;
            act = (hh[j] < HA) && (hv[j] < VA);
            exp = (act && hh[j] >= 2 && hv[j] >= 2) ? 24'hFFFFFF : 24'h0;
            tests_run++;
            if (vid.out_data !== exp || vid.out_vde !== act) begin
                tests_failed++;
                $display("FAIL saturation: data=%h vde=%b at h=%0d v=%0d, expected %h %b",
                         vid.out_data, vid.out_vde, hh[j], hv[j], exp, act);
            end
        end
    endtask

    task automatic test_bypass();
        int j;
        logic act;
        logic [23:0] exp;
        run_to_origin(1'b0, 24'h0);
        for (int k = 0; k < VF * HF; k++) begin
            step(1'b0, 24'($urandom));
            j   = (npix - 4) % HN;
            act = (hh[j] < HA) && (hv[j] < VA);
            exp = act ? hd[j] : 24'h0;
            tests_run++;
            if (vid.out_data !== exp || vid.out_vde !== act ||
                int'(vid.out_hcnt) != hh[j] || int'(vid.out_vcnt) != hv[j]) begin
                tests_failed++;
                $display("FAIL bypass: data=%h vde=%b h=%0d v=%0d, expected %h %b %0d %0d",
                         vid.out_data, vid.out_vde, vid.out_hcnt, vid.out_vcnt,
                         exp, act, hh[j], hv[j]);
            end
        end
    endtask

    // Odd columns 0x60, even 0: filtered gives 0x20 (even h) / 0x40 (odd h), bypass shows raw.
    task automatic test_toggle();
        int j;
        logic act;
        logic [23:0] exp;
        run_to_origin(1'b0, 24'h0);
        for (int k = 0; k < VF * HF; k++) begin
            step(h_cur >= 8, (h_cur % 2 == 1) ? 24'h606060 : 24'h0);
            j   = (npix - 4) % HN;
            act = (hh[j] < HA) && (hv[j] < VA);
            if (!act) exp = 24'h0;
            else if (hh[j] >= 8) exp = (hv[j] < 2) ? 24'h0 :
                                       (hh[j] % 2 == 1) ? 24'h404040 : 24'h202020;
            else exp = (hh[j] % 2 == 1) ? 24'h606060 : 24'h0;
            tests_run++;
            if (vid.out_data !== exp || vid.out_vde !== act) begin
                tests_failed++;
                $display("FAIL toggle: data=%h vde=%b at h=%0d v=%0d, expected %h %b",
                         vid.out_data, vid.out_vde, hh[j], hv[j], exp, act);
            end
        end
    endtask

    task automatic test_mid_reset();
        int j, rel;
        logic act, hit, pulsed;
        logic [23:0] exp;
        hit = 1'b0;
        rel = 0;
        run_to_origin(1'b1, 24'h404040);
        for (int k = 0; k < VF * HF; k++) begin
            pulsed = 1'b0;
            if (!hit && h_cur == 0 && v_cur == 5) begin
                rstn = 1'b0;
                #1;
                pulsed = 1'b1;
                tests_run++;
                if (vid.out_data !== 24'h0 || vid.out_vde !== 1'b0 || vid.out_hcnt !== 0 ||
                    vid.out_vcnt !== 0) begin
                    tests_failed++;
                    $display("FAIL midreset_async: data=%h vde=%b h=%0d v=%0d, expected zero",
                             vid.out_data, vid.out_vde, vid.out_hcnt, vid.out_vcnt);
                end
            end
            step(1'b1, 24'h404040);
            if (pulsed) begin
                rstn = 1'b1;
                rel  = npix;
                hit  = 1'b1;
            end
            j   = (npix - 4) % HN;
            act = (hh[j] < HA) && (hv[j] < VA);
            tests_run++;
            if (!hit) begin
                exp = (act && hh[j] >= 2 && hv[j] >= 2) ? 24'h404040 : 24'h0;
                if (vid.out_data !== exp || vid.out_vde !== act) begin
                    tests_failed++;
                    $display("FAIL midreset_pre: data=%h vde=%b at h=%0d v=%0d, expected %h %b",
                             vid.out_data, vid.out_vde, hh[j], hv[j], exp, act);
                end
            end else if (npix - 4 < rel) begin
                if (vid.out_data !== 24'h0) begin
                    tests_failed++;
                    $display("FAIL midreset_flush: data=%h, expected 0", vid.out_data);
                end
            end else if (vid.out_data !== 24'h0 || vid.out_vde !== act ||
                         int'(vid.out_hcnt) != hh[j] || int'(vid.out_vcnt) != hv[j]) begin
                tests_failed++;
                $display("FAIL midreset_black: data=%h vde=%b h=%0d v=%0d, expected 0 %b %0d %0d",
                         vid.out_data, vid.out_vde, vid.out_hcnt, vid.out_vcnt,
                         act, hh[j], hv[j]);
            end
        end
        for (int k = 0; k < VF * HF; k++) step(1'b1, 24'h404040);
        for (int k = 0; k < VF * HF; k++) begin
            step(1'b1, 24'h404040);
            j   = (npix - 4) % HN;
            act = (hh[j] < HA) && (hv[j] < VA);
            exp = (act && hh[j] >= 2 && hv[j] >= 2) ? 24'h404040 : 24'h0;
            tests_run++;
            if (vid.out_data !== exp || vid.out_vde !== act) begin
                tests_failed++;
                $display("FAIL midreset_recover: data=%h vde=%b at h=%0d v=%0d, expected %h %b",
                         vid.out_data, vid.out_vde, hh[j], hv[j], exp, act);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        h_cur        = 0;
        v_cur        = 0;
        npix         = 0;
        rstn         = 1'b1;
        vid.en       = 1'b0;
        vid.in_data  = 24'h0;
        vid.in_hcnt  = '0;
        vid.in_vcnt  = '0;
        test_reset();
        test_uniform();
        test_impulse();
        test_saturation();
        test_bypass();
        test_toggle();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
